// File: rtl/trans_array_driver.sv
// trans_array_driver
// Drives CH ultrasonic transducer channels with a phase-shifted square carrier.
// A free-running base counter defines the carrier period. Each channel compares
// its phase-rotated copy of that counter against a latched duty value. A small
// IDLE/ARM/RUN sequencer gates the outputs so that a burst always starts and
// ends on a period boundary.

module trans_array_driver #(
    parameter int CH     = 4,
    parameter int PERIOD = 1250,
    parameter int CW     = 11
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          start,
    input  logic          stop,
    input  logic [7:0]    burst_len,
    input  logic [CW-1:0] duty,
    input  logic          ph_we,
    input  logic [3:0]    ph_addr,
    input  logic [CW-1:0] ph_data,
    output logic [CH-1:0] trans,
    output logic          busy,
    output logic          done,
    output logic          tick
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // Last counter value of a period, and the period itself widened by one bit
    // so that PERIOD == 2**CW is still representable.
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
    localparam logic [CW:0]   PERIOD_W = (CW + 1)'(PERIOD);
    localparam logic [4:0]    CH_W     = 5'(CH);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    per_q, per_d;
    logic [7:0]    bl_q, bl_d;
    logic [CW-1:0] duty_q, duty_d;
    logic          stop_pend_q, stop_pend_d;
    logic [CW-1:0] phase_q [CH];
    logic [CW-1:0] phase_d [CH];
    logic [CH-1:0] trans_q, trans_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          tick_q, tick_d;

    logic          tick_now_s;
    logic          stop_req_s;
    logic          burst_end_s;
    logic          run_hold_s;
    logic [CW:0]   dist_s [CH];

    // Base counter: free-running 0..PERIOD-1; tick is registered one cycle early
    // so that it is high exactly while the counter sits at PERIOD-1.
    always_comb begin
        tick_now_s = (cnt_q == CNT_LAST);
        if (tick_now_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
        tick_d = (cnt_d == CNT_LAST);
    end

    // Sequencer: next state, latched burst parameters, stop bookkeeping, done.
    always_comb begin
        state_d     = state_q;
        per_d       = per_q;
        bl_d        = bl_q;
        duty_d      = duty_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;

        // A stop raised in the boundary cycle itself still ends at that boundary.
        stop_req_s  = stop_pend_q | stop;
        burst_end_s = (bl_q != 8'd0) && (per_q == (bl_q - 8'd1));

        case (state_q)
            S_IDLE: begin
                stop_pend_d = 1'b0;
                if (start) begin
                    state_d = S_ARM;
                    bl_d    = burst_len;
                    duty_d  = duty;
                    per_d   = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ARM: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
                if (tick_now_s) begin
                    if (stop_req_s) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_ARM;
                end
            end
            S_RUN: begin
                if (stop) begin
                    stop_pend_d = 1'b1;
                end else begin
                    stop_pend_d = stop_pend_q;
                end
                if (tick_now_s) begin
                    // Burst end and stop share one exit path: one done pulse.
                    if (stop_req_s || burst_end_s) begin
                        state_d     = S_IDLE;
                        stop_pend_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        per_d   = per_q + 8'd1;
                    end
                end else begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d     = S_IDLE;
                stop_pend_d = 1'b0;
            end
        endcase

        busy_d     = (state_d != S_IDLE);
        // The sample taken in the final RUN cycle would appear once already in
        // IDLE, so only samples whose successor cycle is still RUN are kept.
        run_hold_s = (state_q == S_RUN) && (state_d == S_RUN);
    end

    // Phase table: a write is taken only for an existing channel and an
    // in-range offset.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            if (ph_we && ({1'b0, ph_addr} < CH_W) && ({1'b0, ph_data} < PERIOD_W)
                && (ph_addr == 4'(i))) begin
                phase_d[i] = ph_data;
            end else begin
                phase_d[i] = phase_q[i];
            end
        end
    end

    // Per-channel drive: distance of the counter past the channel phase,
    // modulo PERIOD, compared against the latched duty.
    always_comb begin
        trans_d = '0;
        for (int i = 0; i < CH; i++) begin
            if (cnt_q >= phase_q[i]) begin
                dist_s[i] = {1'b0, cnt_q} - {1'b0, phase_q[i]};
            end else begin
                dist_s[i] = {1'b0, cnt_q} + PERIOD_W - {1'b0, phase_q[i]};
            end
            trans_d[i] = run_hold_s && (dist_s[i] < {1'b0, duty_q});
        end
    end

    // All state and output registers, with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            per_q       <= 8'd0;
            bl_q        <= 8'd0;
            duty_q      <= '0;
            stop_pend_q <= 1'b0;
            trans_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tick_q      <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                phase_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            per_q       <= per_d;
            bl_q        <= bl_d;
            duty_q      <= duty_d;
            stop_pend_q <= stop_pend_d;
            trans_q     <= trans_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tick_q      <= tick_d;
            for (int i = 0; i < CH; i++) begin
                phase_q[i] <= phase_d[i];
            end
        end
    end

    assign trans = trans_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_trans_array_driver.sv
// Directed bench for trans_array_driver (CH=4, PERIOD=1250, CW=11).
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.

module tb_trans_array_driver;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [7:0]  burst_len;
    logic [10:0] duty;
    logic        ph_we;
    logic [3:0]  ph_addr;
    logic [10:0] ph_data;
    logic [3:0]  trans;
    logic        busy;
    logic        done;
    logic        tick;

    int checks = 0;
    int errors = 0;
    int tb_cnt = 0;     // expected base counter value in the current cycle
    int ph_m [4];       // expected phase table

    trans_array_driver #(.CH(4), .PERIOD(1250), .CW(11)) dut (
        .CLK       (clk),
        .RST       (rst),
        .start     (start),
        .stop      (stop),
        .burst_len (burst_len),
        .duty      (duty),
        .ph_we     (ph_we),
        .ph_addr   (ph_addr),
        .ph_data   (ph_data),
        .trans     (trans),
        .busy      (busy),
        .done      (done),
        .tick      (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
        tb_cnt = (tb_cnt == 1249) ? 0 : tb_cnt + 1;
    endtask

    // Expected channel pattern for base counter value c under duty dty.
    function automatic logic [3:0] model_trans(input int c, input int dty);
        logic [3:0] r;
        int d;
        r = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            d = (c >= ph_m[i]) ? c - ph_m[i] : c + 1250 - ph_m[i];
            r[i] = (d < dty);
        end
        return r;
    endfunction

    task automatic write_phase(input int addr, input int data);
        ph_we   = 1'b1;
        ph_addr = 4'(addr);
        ph_data = 11'(data);
        step();
        ph_we   = 1'b0;
        if (addr < 4 && data < 1250) ph_m[addr] = data;
    endtask

    // Issue start in IDLE, then follow ARM until RUN begins at counter 0.
    task automatic do_start(input int bl, input int dty, input bit with_stop);
        int arm_bad;
        burst_len = 8'(bl);
        duty      = 11'(dty);
        start     = 1'b1;
        stop      = with_stop;
        step();
        start     = 1'b0;
        stop      = 1'b0;
        arm_bad   = 0;
        do begin
            if (busy !== 1'b1 || trans !== 4'b0000 || done !== 1'b0) arm_bad++;
            step();
        end while (tb_cnt != 0);
        checks++;
        if (arm_bad != 0) begin
            errors++;
            $display("FAIL arm_phase: %0d cycles off, required busy=1 trans=0000 done=0", arm_bad);
        end
    endtask

    // Check nper carrier periods of RUN starting at counter 0, optional stop
    // pulse at counter 500 of period stop_p, optional ignored start at counter
    // 100 of period poke_p, then the single done pulse and return to IDLE.
    task automatic check_run(input int nper, input int dty, input int stop_p,
                             input int poke_p, input string nm);
        logic [3:0] exp_t;
        int prev;
        for (int p = 0; p < nper; p++) begin
            for (int k = 0; k < 1250; k++) begin
                prev  = (k == 0) ? 1249 : k - 1;
                exp_t = (p == 0 && k == 0) ? 4'b0000 : model_trans(prev, dty);
                checks++;
                if (trans !== exp_t) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL %s_trans p=%0d k=%0d got %b required %b", nm, p, k, trans, exp_t);
                end
                checks++;
                if (busy !== 1'b1 || done !== 1'b0 || tick !== (k == 1249)) begin
                    errors++;
                    if (errors < 20)
                        $display("FAIL %s_ctrl p=%0d k=%0d got busy=%b done=%b tick=%b", nm, p, k, busy, done, tick);
                end
                stop = (p == stop_p && k == 500);
                if (p == poke_p && k == 100) begin
                    start     = 1'b1;
                    duty      = 11'd0;
                    burst_len = 8'd1;
                end else begin
                    start = 1'b0;
                end
                step();
            end
        end
        stop  = 1'b0;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || trans !== 4'b0000) begin
            errors++;
            $display("FAIL %s_end got done=%b busy=%b trans=%b required 1 0 0000", nm, done, busy, trans);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_single_done got done=%b busy=%b required 0 0", nm, done, busy);
        end
    endtask

    task automatic test_reset();
        int nticks;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (trans !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs got trans=%b busy=%b done=%b tick=%b", trans, busy, done, tick);
            end
        end
        rst    = 1'b0;
        tb_cnt = 0;
        for (int i = 0; i < 4; i++) ph_m[i] = 0;
        nticks = 0;
        for (int n = 0; n < 3000; n++) begin
            if (tick === 1'b1) nticks++;
            checks++;
            if (tick !== (tb_cnt == 1249) || trans !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                if (errors < 20)
                    $display("FAIL idle n=%0d got tick=%b trans=%b busy=%b done=%b", n, tick, trans, busy, done);
            end
            stop = (n >= 2000 && n < 2010);   // stop in IDLE must be ignored
            step();
        end
        stop = 1'b0;
        checks++;
        if (nticks != 2) begin
            errors++;
            $display("FAIL idle_tick_count got %0d required 2", nticks);
        end
    endtask

    task automatic test_burst();
        do_start(3, 625, 1'b0);
        check_run(3, 625, -1, 0, "burst3");
        duty = 11'd625;
    endtask

    task automatic test_phase();
        write_phase(0, 0);
        write_phase(1, 312);
        write_phase(2, 625);
        write_phase(3, 1249);
        write_phase(4, 600);      // no such channel: ignored
        write_phase(2, 1250);     // out of range: ignored
        do_start(2, 625, 1'b0);
        check_run(2, 625, -1, -1, "phase");
    endtask

    task automatic test_continuous();
        do_start(0, 625, 1'b0);
        check_run(6, 625, 5, -1, "cont");
        stop = 1'b1;
        step();
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL stop_in_idle got busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_coincide();
        do_start(1, 625, 1'b0);
        check_run(1, 625, 0, -1, "coincide");
        do_start(2, 625, 1'b1);   // stop together with start is ignored
        check_run(2, 625, -1, -1, "start_stop");
    endtask

    task automatic test_duty();
        do_start(1, 0, 1'b0);
        check_run(1, 0, -1, -1, "duty0");
        do_start(1, 1300, 1'b0);
        check_run(1, 1300, -1, -1, "duty1300");
    endtask

    task automatic test_reset_mid();
        do_start(3, 625, 1'b0);
        for (int k = 0; k < 700; k++) step();
        rst = 1'b1;
        step();
        checks++;
        if (trans !== 4'b0000 || busy !== 1'b0 || done !== 1'b0 || tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got trans=%b busy=%b done=%b tick=%b", trans, busy, done, tick);
        end
        step();
        rst = 1'b0;
        tb_cnt = 0;
        for (int i = 0; i < 4; i++) ph_m[i] = 0;
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done got done=%b busy=%b", done, busy);
        end
        write_phase(1, 1250);     // ignored, phase stays 0
        write_phase(0, 2047);     // ignored, phase stays 0
        do_start(1, 625, 1'b0);
        check_run(1, 625, -1, -1, "post_reset");
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        stop      = 1'b0;
        burst_len = 8'd0;
        duty      = 11'd0;
        ph_we     = 1'b0;
        ph_addr   = 4'd0;
        ph_data   = 11'd0;
        test_reset();
        test_burst();
        test_phase();
        test_continuous();
        test_coincide();
        test_duty();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
